bcd_seg_scan: RTL and testbench

Multiplexed multi-digit BCD-to-seven-segment display driver. It is the scanned, parametrised successor to the single-digit combinational decoder. It accepts a packed BCD word through a load strobe and double-buffers it so that updates only take effect at frame boundaries. It then time-multiplexes one shared active-low segment bus across `DIGITS` common-anode digit enables. It sits between any numeric producer (counter, measurement block) and the board display pins.

---
 rtl/bcd_seg_pkg.sv | 24 ++
 rtl/bcd_seg_dec.sv | 32 +++
 rtl/bcd_seg_scan.sv | 166 ++++++++++++++++
 tb/tb_bcd_seg_scan.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg_pkg.sv
// rtl/bcd_seg_pkg.sv - shared segment type and active-low seven-segment code constants
//
// Purpose: common definitions for the scanned BCD seven-segment driver.
//   seg7_t holds segments abcdefg, with a in bit 6 and g in bit 0.
//   All codes are active-low: a 0 lights the segment.
// Ports: none (package).
package bcd_seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'b0000001;
    localparam seg7_t SEG_1     = 7'b1001111;
    localparam seg7_t SEG_2     = 7'b0010010;
    localparam seg7_t SEG_3     = 7'b0000110;
    localparam seg7_t SEG_4     = 7'b1001100;
    localparam seg7_t SEG_5     = 7'b0100100;
    localparam seg7_t SEG_6     = 7'b0100000;
    localparam seg7_t SEG_7     = 7'b0001111;
    localparam seg7_t SEG_8     = 7'b0000000;
    localparam seg7_t SEG_9     = 7'b0000100;
    localparam seg7_t SEG_ERR   = 7'b0110000;
    localparam seg7_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_seg_dec.sv
// rtl/bcd_seg_dec.sv - combinational 4-bit BCD to active-low seven-segment decoder
//
// Purpose: map one BCD nibble to its segment pattern. Non-BCD nibbles (10..15)
//   show the error glyph "E".
// Ports:
//   bcd  in  4 : nibble to decode
//   seg  out 7 : active-low segments abcdefg (a = bit 6)
module bcd_seg_dec
    import bcd_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_ERR;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// rtl/bcd_seg_scan.sv - multiplexed multi-digit BCD seven-segment scan driver
//
// Purpose: double-buffers a packed BCD word and decimal points, commits them at
//   frame boundaries, and time-multiplexes one shared active-low segment bus
//   across DIGITS active-low common-anode enables.
// Optional feature: define BCD_SEG_LZB_EN to compile in leading-zero blanking.
// Parameters:
//   DIGITS    (1..8)  digits scanned, digit 0 least significant
//   PRESCALE  (>= 2)  clock cycles each digit stays enabled
// Ports:
//   clk    in  1          : clock, rising edge
//   rst_n  in  1          : asynchronous active-low reset
//   load   in  1          : strobe capturing bcd/dp into the shadow register
//   bcd    in  4*DIGITS   : packed BCD, nibble k drives digit k
//   dp     in  DIGITS     : decimal point request per digit, active-high
//   blank  in  1          : level, darkens all digits while high
//   seg    out 7          : segments abcdefg, active-low
//   dpo    out 1          : decimal point, active-low
//   an     out DIGITS     : digit enables, active-low
//   frame  out 1          : one-cycle pulse aligned with the first cycle of digit 0
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank,
    output seg7_t                 seg,
    output logic                  dpo,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                cnt_last;
    logic                boundary;

    logic [4*DIGITS-1:0] shadow_bcd;
    logic [DIGITS-1:0]   shadow_dp;
    logic                pending;
    logic [4*DIGITS-1:0] disp_bcd;
    logic [DIGITS-1:0]   disp_dp;
    logic                valid;

    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          nib;
    logic                dp_sel;
    logic                lz_sel;
    logic                lit;
    logic [DIGITS-1:0]   an_next;
    seg7_t               seg_dec;

    assign cnt_last = (cnt == PW'(PRESCALE - 1));
    assign boundary = cnt_last && (idx == IW'(DIGITS - 1));

    // Prescaler and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    // Shadow and display registers. A load in the boundary cycle bypasses the
    // shadow so it lands in the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_bcd <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            disp_bcd   <= '0;
            disp_dp    <= '0;
            valid      <= 1'b0;
        end else begin
            if (load) begin
                shadow_bcd <= bcd;
                shadow_dp  <= dp;
            end
            if (boundary && (load || pending)) begin
                disp_bcd <= load ? bcd : shadow_bcd;
                disp_dp  <= load ? dp  : shadow_dp;
                valid    <= 1'b1;
                pending  <= 1'b0;
            end else if (load) begin
                pending  <= 1'b1;
            end
        end
    end

`ifdef BCD_SEG_LZB_EN
    // A digit above 0 is dark while it and everything above it are zero
    // without a decimal point; error nibbles are non-zero so they stop it.
    always_comb begin
        logic lead;
        lead    = 1'b1;
        lz_mask = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead       = lead && (disp_bcd[4*k +: 4] == 4'd0) && !disp_dp[k];
            lz_mask[k] = lead;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Select the nibble, decimal point and blanking bit of the current digit.
    always_comb begin
        nib    = '0;
        dp_sel = 1'b0;
        lz_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib    = disp_bcd[4*k +: 4];
                dp_sel = disp_dp[k];
                lz_sel = lz_mask[k];
            end
        end
    end

    bcd_seg_dec u_dec (
        .bcd (nib),
        .seg (seg_dec)
    );

    assign lit = valid && !blank && !lz_sel;

    always_comb begin
        an_next = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (lit && (idx == IW'(k))) begin
                an_next[k] = 1'b0;
            end
        end
    end

    // Enables and segments share one register stage so they always switch
    // together and never ghost one digit's pattern onto its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an    <= '1;
            seg   <= SEG_BLANK;
            dpo   <= 1'b1;
            frame <= 1'b0;
        end else begin
            an    <= an_next;
            seg   <= lit ? seg_dec : SEG_BLANK;
            dpo   <= lit ? !dp_sel : 1'b1;
            frame <= boundary;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb/tb_bcd_seg_scan.sv - scoreboard bench for the scanned BCD seven-segment driver
module tb_bcd_seg_scan;

    localparam int D  = 4;
    localparam int P  = 4;
    localparam int FR = D * P;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] bcd   = '0;
    logic [3:0]  dp    = '0;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  an;
    logic        frame;

    bcd_seg_scan #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .bcd   (bcd),
        .dp    (dp),
        .blank (blank),
        .seg   (seg),
        .dpo   (dpo),
        .an    (an),
        .frame (frame)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Expected {an, seg, dpo, frame} for each upcoming rising edge.
    logic [12:0] expq[$];

    // Reference model: time since reset plus the committed/pending values.
    int          s;
    logic [15:0] m_disp, m_shadow;
    logic [3:0]  m_dpd, m_dps;
    bit          m_pend, m_valid;

    function automatic logic [6:0] seg_code(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b0110000;
        endcase
    endfunction

    function automatic bit lz_dark(input int k, input logic [15:0] v, input logic [3:0] d);
`ifdef BCD_SEG_LZB_EN
        return (k > 0) && ((int'(v) >> (4 * k)) == 0) && ((int'(d) >> k) == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        s        = 0;
        m_disp   = '0;
        m_shadow = '0;
        m_dpd    = '0;
        m_dps    = '0;
        m_pend   = 1'b0;
        m_valid  = 1'b0;
    endtask

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input bit ld, input logic [15:0] b, input logic [3:0] d, input bit bl);
        int          dig;
        bit          fr;
        logic [3:0]  an_e;
        logic [12:0] e;
        @(negedge clk);
        load  = ld;
        bcd   = b;
        dp    = d;
        blank = bl;
        dig = (s / P) % D;
        fr  = ((s % FR) == FR - 1);
        if (m_valid && !bl && !lz_dark(dig, m_disp, m_dpd)) begin
            an_e = 4'b1111 & ~(4'd1 << dig);
            e = {an_e, seg_code((int'(m_disp) >> (4 * dig)) & 15), ~m_dpd[dig], fr};
        end else begin
            e = {4'b1111, 7'b1111111, 1'b1, fr};
        end
        expq.push_back(e);
        if (ld) begin
            m_shadow = b;
            m_dps    = d;
            m_pend   = 1'b1;
        end
        if (fr && m_pend) begin
            m_disp  = m_shadow;
            m_dpd   = m_dps;
            m_valid = 1'b1;
            m_pend  = 1'b0;
        end
        s++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if (an !== 4'b1111) begin
            fails++;
            $display("FAIL %s an got %b want 1111", tag, an);
        end
        tests++;
        if (seg !== 7'b1111111) begin
            fails++;
            $display("FAIL %s seg got %b want 1111111", tag, seg);
        end
        tests++;
        if (dpo !== 1'b1) begin
            fails++;
            $display("FAIL %s dpo got %b want 1", tag, dpo);
        end
        tests++;
        if (frame !== 1'b0) begin
            fails++;
            $display("FAIL %s frame got %b want 0", tag, frame);
        end
    endtask

    // Monitor: every edge with a prediction pending is compared.
    always @(posedge clk) begin
        logic [12:0] exp_v;
        logic [12:0] act_v;
        cyc++;
        #1;
        if (expq.size() > 0) begin
            exp_v = expq.pop_front();
            act_v = {an, seg, dpo, frame};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL scan cycle=%0d got an=%b seg=%b dpo=%b frame=%b want an=%b seg=%b dpo=%b frame=%b",
                         cyc, act_v[12:9], act_v[8:2], act_v[1], act_v[0],
                         exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
            end
        end
    end

    initial begin
        logic [15:0] rb;
        logic [3:0]  rd;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;

        // No load yet: dark with frame pulses.
        idle(40);

        // Basic display with a decimal point on digit 1.
        step(1'b1, 16'h1234, 4'b0010, 1'b0);
        idle(40);

        // Error nibble on digit 2.
        step(1'b1, 16'h1F34, 4'b0000, 1'b0);
        idle(36);

        // Two loads inside one frame: last wins.
        step(1'b1, 16'h1111, 4'b0000, 1'b0);
        idle(3);
        step(1'b1, 16'h2222, 4'b0000, 1'b0);
        idle(36);

        // Load exactly in the boundary cycle.
        while ((s % FR) != FR - 1) step(1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 16'h5678, 4'b1000, 1'b0);
        idle(36);

        // Leading zeros.
        step(1'b1, 16'h0050, 4'b0000, 1'b0);
        idle(40);

        // Blank for 10 cycles mid-frame.
        idle(5);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 4'h0, 1'b1);
        idle(30);

        // Asynchronous reset mid-scan with a value shown.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        expq.delete();
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(20);

        // Randomised traffic, zero-heavy to exercise leading digits.
        for (int i = 0; i < 400; i++) begin
            rb = '0;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(1, 0) == 1) rb[4*k +: 4] = 4'($urandom_range(15, 0));
            end
            rd = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'h0;
            step($urandom_range(7, 0) == 0, rb, rd, $urandom_range(19, 0) == 0);
        end
        idle(2);

        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain queue size got %0d want 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
